// File: rtl/bist_pkg.sv
// Shared BIST definitions: run-state encoding, default MISR constants and
// the control bundle the analyzer FSM hands to its datapath.
package bist_pkg;

  // Run-protocol states, encoded identically on the controller side.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPACT = 2'd1,
    ST_CHECK   = 2'd2,
    ST_DONE    = 2'd3
  } bist_state_e;

  // Default MISR geometry and golden values for the standard 8-bit CUT.
  localparam int         DEF_WIDTH      = 8;
  localparam logic [7:0] DEF_POLY       = 8'h1D;
  localparam logic [7:0] DEF_SEED       = 8'h00;
  localparam logic [7:0] DEF_GOLDEN     = 8'h15;
  localparam int         DEF_EXP_CYCLES = 4;
  localparam int         DEF_COUNT_W    = 16;

  // Per-cycle datapath commands decoded from the FSM state and inputs.
  typedef struct packed {
    logic misr_load;     // restart the MISR from the seed
    logic misr_step;     // fold CUT_OUT into the MISR
    logic cnt_first;     // this is response cycle number one
    logic cnt_inc;       // one more response cycle
    logic err_set;       // protocol violation seen
    logic verdict_clr;   // new run: drop DONE/PASS/FAIL/ERR
    logic verdict_latch; // capture the pass/fail decision
  } bist_ctrl_t;

endpackage

// File: rtl/bist_response_analyzer_if.sv
// Run-protocol and status bundle between the BIST controller / CUT side
// (master) and the response analyzer (slave).
interface bist_response_analyzer_if
  import bist_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             RUNNING;
  logic             BIST_END;
  logic [WIDTH-1:0] CUT_OUT;
  logic [WIDTH-1:0] SIGNATURE;
  logic             DONE;
  logic             PASS;
  logic             FAIL;
  logic             ERR;

  modport master (
    output RUNNING, BIST_END, CUT_OUT,
    input  SIGNATURE, DONE, PASS, FAIL, ERR
  );

  modport slave (
    input  RUNNING, BIST_END, CUT_OUT,
    output SIGNATURE, DONE, PASS, FAIL, ERR
  );

endinterface

// File: rtl/bist_misr.sv
// Multiple-input signature register. A load restarts from the seed; a step
// folds one response word in. Load and step together compact the first word
// of a run directly on top of the seed, so no cycle is lost at run start.
module bist_misr
  import bist_pkg::*;
#(
  parameter int               WIDTH = DEF_WIDTH,
  parameter logic [WIDTH-1:0] POLY  = DEF_POLY
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] seed,
  input  logic             load_seed,
  input  logic             step,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] sig
);

  logic [WIDTH-1:0] base;

  // Shift left, feed the MSB back through the polynomial, xor the response in.
  function automatic logic [WIDTH-1:0] misr_next(input logic [WIDTH-1:0] m,
                                                 input logic [WIDTH-1:0] d);
    return {m[WIDTH-2:0], 1'b0} ^ (m[WIDTH-1] ? POLY : '0) ^ d;
  endfunction

  // Select the value the next step builds on: seed at run start, else current.
  always_comb begin
    base = load_seed ? seed : sig;
  end

  // Signature register; reset discards any partial signature.
  always_ff @(posedge CLK) begin
    // NOTE: state is updated with <= so every register samples pre-edge values.
    if (RESET) begin
      sig <= seed;
    end else if (step) begin
      sig <= misr_next(base, data);
    end else if (load_seed) begin
      sig <= seed;
    end
  end

endmodule

// File: rtl/bist_response_analyzer.sv
// BIST response analyzer: compacts CUT responses while RUNNING is high,
// then on BIST_END compares signature and response-cycle count against the
// golden values and presents a registered PASS/FAIL verdict.
module bist_response_analyzer
  import bist_pkg::*;
#(
  parameter int               WIDTH      = DEF_WIDTH,
  parameter logic [WIDTH-1:0] POLY       = DEF_POLY,
  parameter logic [WIDTH-1:0] SEED       = DEF_SEED,
  parameter logic [WIDTH-1:0] GOLDEN     = DEF_GOLDEN,
  parameter int               EXP_CYCLES = DEF_EXP_CYCLES,
  parameter int               COUNT_W    = DEF_COUNT_W
) (
  input logic                      CLK,
  input logic                      RESET,
  bist_response_analyzer_if.slave  bus
);

  localparam logic [COUNT_W-1:0] EXP_COUNT = COUNT_W'(EXP_CYCLES);
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  bist_state_e        state;
  bist_state_e        state_next;
  bist_ctrl_t         ctrl;
  logic [WIDTH-1:0]   sig;
  logic [COUNT_W-1:0] count;
  logic               done_q;
  logic               pass_q;
  logic               fail_q;
  logic               err_q;
  logic               pass_now;

  bist_misr #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_misr (
    .CLK       (CLK),
    .RESET     (RESET),
    .seed      (SEED),
    .load_seed (ctrl.misr_load),
    .step      (ctrl.misr_step),
    .data      (bus.CUT_OUT),
    .sig       (sig)
  );

  // A run passes only with the right signature, the right number of
  // response cycles and a clean protocol history.
  assign pass_now = (sig == GOLDEN) && (count == EXP_COUNT) && !err_q;

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and datapath command decode.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_next = state;
    ctrl       = '0;
    unique case (state)
      ST_IDLE: begin
        if (bus.RUNNING && bus.BIST_END) begin
          ctrl.err_set = 1'b1;
          state_next   = ST_CHECK;
        end else if (bus.RUNNING) begin
          ctrl.misr_load = 1'b1;
          ctrl.misr_step = 1'b1;
          ctrl.cnt_first = 1'b1;
          state_next     = ST_COMPACT;
        end
      end
      ST_COMPACT: begin
        if (bus.RUNNING && bus.BIST_END) begin
          ctrl.err_set = 1'b1;
          state_next   = ST_CHECK;
        end else if (bus.RUNNING) begin
          ctrl.misr_step = 1'b1;
          ctrl.cnt_inc   = 1'b1;
        end else if (bus.BIST_END) begin
          state_next = ST_CHECK;
        end
      end
      ST_CHECK: begin
        ctrl.verdict_latch = 1'b1;
        state_next         = ST_DONE;
      end
      ST_DONE: begin
        if (bus.RUNNING) begin
          ctrl.verdict_clr = 1'b1;
          ctrl.misr_load   = 1'b1;
          ctrl.misr_step   = 1'b1;
          ctrl.cnt_first   = 1'b1;
          state_next       = ST_COMPACT;
        end
      end
    endcase
  end

  // Response-cycle counter; saturates instead of wrapping.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      count <= '0;
    end else if (ctrl.cnt_first) begin
      count <= COUNT_W'(1);
    end else if (ctrl.cnt_inc && (count != COUNT_MAX)) begin
      count <= count + COUNT_W'(1);
    end
  end

  // Verdict and sticky protocol-error flags.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      done_q <= 1'b0;
      pass_q <= 1'b0;
      fail_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (ctrl.verdict_clr) begin
      done_q <= 1'b0;
      pass_q <= 1'b0;
      fail_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (ctrl.err_set) begin
        err_q <= 1'b1;
      end
      if (ctrl.verdict_latch) begin
        done_q <= 1'b1;
        pass_q <= pass_now;
        fail_q <= !pass_now;
      end
    end
  end

  assign bus.SIGNATURE = sig;
  assign bus.DONE      = done_q;
  assign bus.PASS      = pass_q;
  assign bus.FAIL      = fail_q;
  assign bus.ERR       = err_q;

endmodule
